// File: rtl/ram_fifo_ctrl.sv
// FIFO controller for an external RAM with registered reads, plus a 3-entry output buffer.
// Latency: 3 edges push to out_valid when empty; backpressure via registered in_ready.
// Optional synchronous flush input when RAM_FIFO_CTRL_FLUSH_EN is defined.
module ram_fifo_ctrl #(
    parameter int WIDTH   = 8,
    parameter int ENTRIES = 16,
    localparam int AW     = $clog2(ENTRIES),
    localparam int CW     = $clog2(ENTRIES + 4)
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef RAM_FIFO_CTRL_FLUSH_EN
    input  logic             flush,
`endif
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [AW-1:0]    ram_waddr,
    output logic [WIDTH-1:0] ram_write_data,
    output logic             ram_write_enable,
    output logic [AW-1:0]    ram_raddr,
    input  logic [WIDTH-1:0] ram_read_data,
    output logic [CW-1:0]    count
);

    localparam logic [AW:0] FULL = (AW+1)'(ENTRIES);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      ram_words;
    logic [AW:0]      ram_words_nxt;
    logic             rd_pending;
    logic [1:0]       buf_count;
    logic [1:0]       buf_count_nxt;
    logic [1:0]       wr_idx;
    logic [WIDTH-1:0] buf_q   [3];
    logic [WIDTH-1:0] buf_nxt [3];
    logic             in_ready_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_nxt;
    logic             flush_i;
    logic             push;
    logic             pop;
    logic             issue;

`ifdef RAM_FIFO_CTRL_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    // in_ready resets to 1, so the write strobe is also gated by reset itself.
    assign push  = in_valid && in_ready_q && rst_n && !flush_i;
    assign pop   = (buf_count != 2'd0) && out_ready;
    // Issue looks only at registered occupancy, never at out_ready.
    assign issue = (ram_words != '0) && (({1'b0, buf_count} + {2'b00, rd_pending}) < 3'd3);

    always_comb begin
        ram_words_nxt = ram_words;
        if (push && !issue) begin
            ram_words_nxt = ram_words + (AW+1)'(1);
        end else if (!push && issue) begin
            ram_words_nxt = ram_words - (AW+1)'(1);
        end
    end

    // Shift on pop first, then land the returning read at the new tail.
    always_comb begin
        buf_nxt = buf_q;
        if (pop) begin
            buf_nxt[0] = buf_q[1];
            buf_nxt[1] = buf_q[2];
        end
        wr_idx = buf_count - 2'(pop);
        for (int i = 0; i < 3; i++) begin
            if (rd_pending && (wr_idx == 2'(i))) begin
                buf_nxt[i] = ram_read_data;
            end
        end
        buf_count_nxt = buf_count - 2'(pop) + 2'(rd_pending);
    end

    assign count_nxt = count_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ram_words  <= '0;
            rd_pending <= 1'b0;
            buf_count  <= 2'd0;
            in_ready_q <= 1'b1;
            count_q    <= '0;
            for (int i = 0; i < 3; i++) begin
                buf_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ram_words  <= '0;
            rd_pending <= 1'b0;
            buf_count  <= 2'd0;
            in_ready_q <= 1'b1;
            count_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            ram_words  <= ram_words_nxt;
            rd_pending <= issue;
            buf_count  <= buf_count_nxt;
            in_ready_q <= (ram_words_nxt < FULL);
            count_q    <= count_nxt;
            buf_q      <= buf_nxt;
        end
    end

    assign in_ready         = in_ready_q;
    assign out_data         = buf_q[0];
    assign out_valid        = (buf_count != 2'd0);
    assign ram_waddr        = wr_ptr;
    assign ram_write_data   = in_data;
    assign ram_write_enable = push;
    assign ram_raddr        = rd_ptr;
    assign count            = count_q;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: behavioural RAM plus a queue-based reference of the FIFO contents.
module tb_ram_fifo_ctrl;

    localparam int WIDTH   = 8;
    localparam int ENTRIES = 16;
    localparam int AW      = $clog2(ENTRIES);
    localparam int CW      = $clog2(ENTRIES + 4);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [AW-1:0]    ram_waddr;
    logic [WIDTH-1:0] ram_write_data;
    logic             ram_write_enable;
    logic [AW-1:0]    ram_raddr;
    logic [WIDTH-1:0] ram_read_data = '0;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0] mem [ENTRIES];

    int n_chk  = 0;
    int n_pass = 0;
    int pushes = 0;
    int pops   = 0;
    logic [WIDTH-1:0] mq [$];

    always #5 clk = ~clk;

    ram_fifo_ctrl #(.WIDTH(WIDTH), .ENTRIES(ENTRIES)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
`ifdef RAM_FIFO_CTRL_FLUSH_EN
        .flush            (flush),
`endif
        .in_data          (in_data),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .ram_waddr        (ram_waddr),
        .ram_write_data   (ram_write_data),
        .ram_write_enable (ram_write_enable),
        .ram_raddr        (ram_raddr),
        .ram_read_data    (ram_read_data),
        .count            (count)
    );

    always @(posedge clk) begin
        if (ram_write_enable) mem[ram_waddr] <= ram_write_data;
        ram_read_data <= mem[ram_raddr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One clock: entered and left at a negedge; model follows the observed handshakes.
    task automatic cycle(input bit iv, input logic [WIDTH-1:0] d, input bit ordy);
        bit push;
        bit pop;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        push = iv && in_ready && !flush;
        pop  = out_valid && ordy;
        if (!in_ready) chk("full_cnt", 32'(count >= CW'(ENTRIES)), 1);
        if (pop) begin
            if (mq.size() == 0) chk("pop_unexpected", 1, 0);
            else chk("pop_data", out_data, mq.pop_front());
            pops++;
        end
        if (push) begin
            mq.push_back(d);
            pushes++;
        end
        if (flush) mq.delete();
        @(negedge clk);
        chk("count", count, mq.size());
    endtask

    initial begin
        int base;
        int pbase;

        // Reset state, with in_valid high to confirm no write strobe leaks out.
        in_valid = 1'b1;
        in_data  = 8'h5A;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_count", count, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_wr_en", ram_write_enable, 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Single word latency: out_valid appears after the third edge.
        cycle(1'b1, 8'hA5, 1'b1);
        chk("lat_e1_vld", out_valid, 0);
        cycle(1'b0, 8'h00, 1'b1);
        chk("lat_e2_vld", out_valid, 0);
        cycle(1'b0, 8'h00, 1'b1);
        chk("lat_e3_vld", out_valid, 1);
        chk("lat_e3_data", out_data, 8'hA5);
        chk("lat_e3_cnt", count, 1);
        cycle(1'b0, 8'h00, 1'b1);
        chk("lat_e4_vld", out_valid, 0);
        chk("lat_e4_cnt", count, 0);

        // Fill: RAM plus output buffer hold ENTRIES+3 words.
        base = pushes;
        for (int i = 0; i < 30; i++) cycle(1'b1, 8'(pushes - base), 1'b0);
        chk("fill_accepted", pushes - base, ENTRIES + 3);
        chk("fill_in_ready", in_ready, 0);
        chk("fill_count", count, ENTRIES + 3);
        for (int i = 0; i < 30; i++) cycle(1'b0, 8'h00, 1'b1);
        chk("fill_drained", count, 0);

        // Streaming: one pop per cycle once the pipe fills, pointers wrap.
        base  = pushes;
        pbase = pops;
        for (int k = 0; k < 100; k++) begin
            if (k >= 3) chk("stream_vld", out_valid, 1);
            cycle(1'b1, 8'(pushes - base), 1'b1);
        end
        chk("stream_pushed", pushes - base, 100);
        for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b1);
        chk("stream_popped", pops - pbase, 100);

        // Random traffic, push-heavy then pop-heavy.
        for (int i = 0; i < 10000; i++) begin
            if (i < 5000)
                cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 1) != 0);
            else
                cycle($urandom_range(0, 1) != 0, 8'($urandom), $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 40; i++) cycle(1'b0, 8'h00, 1'b1);
        chk("rand_empty", mq.size(), 0);
        chk("rand_count", count, 0);

        // Reset mid-operation with 10 words held and a read in flight.
        for (int i = 0; i < 11; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
        chk("mid_pre_cnt", count, 10);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", out_valid, 0);
        chk("mid_rst_cnt", count, 0);
        chk("mid_rst_rdy", in_ready, 1);
        mq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        pbase = pops;
        cycle(1'b1, 8'h3C, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b1);
        chk("mid_post_pops", pops - pbase, 1);

`ifdef RAM_FIFO_CTRL_FLUSH_EN
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0);
        chk("fl_pre_cnt", count, 5);
        flush = 1'b1;
        cycle(1'b1, 8'h77, 1'b0);
        flush = 1'b0;
        chk("fl_cnt", count, 0);
        chk("fl_vld", out_valid, 0);
        pbase = pops;
        cycle(1'b1, 8'h11, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b1);
        chk("fl_post_pops", pops - pbase, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
